// File: rtl/star_field.sv
// star_field: scrolling collectible stars with timed respawn, scoring, escape pulses and per-pixel hit test
module star_field #(
  parameter int NUM_STARS      = 4,
  parameter int STAR_SIZE      = 16,
  parameter int SPEED          = 12,
  parameter int SPAWN_X        = 640,
  parameter int Y_RANGE        = 400,
  parameter int RESPAWN_FRAMES = 30,
  parameter int STAGGER_FRAMES = 8,
  parameter int SCORE_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  input  logic [NUM_STARS-1:0] kill,
  output logic                 star_on,
  output logic [2:0]           star_id,
  output logic [NUM_STARS-1:0] alive,
  output logic [SCORE_W-1:0]   score,
  output logic                 escaped,
  output logic                 busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;
  localparam logic [9:0] R = 10'(STAR_SIZE / 2 - 1);
  localparam logic [9:0] SS = 10'(STAR_SIZE);
  localparam logic [9:0] SP = 10'(SPEED);
  localparam logic [9:0] SX = 10'(SPAWN_X);
  localparam logic [9:0] YR = 10'(Y_RANGE);
  localparam logic [5:0] RF = 6'(RESPAWN_FRAMES);
  logic [0:0]           state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [NUM_STARS-1:0] alive_q, alive_d, kill_acc;
  logic [9:0]           x_q [NUM_STARS];
  logic [9:0]           x_d [NUM_STARS];
  logic [9:0]           y_q [NUM_STARS];
  logic [9:0]           y_d [NUM_STARS];
  logic [5:0]           rc_q [NUM_STARS];
  logic [5:0]           rc_d [NUM_STARS];
  logic [15:0]          lfsr_q, lfsr_d, lfsr_nx;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 star_on_q, star_on_d, escaped_q, escaped_d;
  logic [2:0]           star_id_q, star_id_d;
  logic [9:0]           v, spawn_y, rx, ry, dx, dy;
  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign v       = {1'b0, lfsr_q[8:0]};
  assign spawn_y = v < YR ? v : v - YR;
  // sweep sequencing, per-star move/escape/respawn, and kill acceptance (kill overrides the sweep)
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    alive_d   = alive_q;
    x_d       = x_q;
    y_d       = y_q;
    rc_d      = rc_q;
    lfsr_d    = lfsr_q;
    escaped_d = 1'b0;
    kill_acc  = kill & alive_q;
    score_d   = score_q;
    if (state_q == IDLE) begin
      state_d = frame_tick ? SWEEP : IDLE;
      idx_d   = '0;
    end else begin
      state_d = idx_q == 3'(NUM_STARS - 1) ? IDLE : SWEEP;
      idx_d   = idx_q == 3'(NUM_STARS - 1) ? 3'd0 : idx_q + 3'd1;
    end
    for (int i = 0; i < NUM_STARS; i++) begin
      if (state_q == SWEEP && idx_q == 3'(i) && !kill_acc[i]) begin
        if (alive_q[i]) begin
          if (x_q[i] < SP) begin
            alive_d[i] = 1'b0;
            rc_d[i]    = 6'd1;
            escaped_d  = 1'b1;
          end else x_d[i] = x_q[i] - SP;
        end else if (rc_q[i] > 6'd1) rc_d[i] = rc_q[i] - 6'd1;
        else begin
          alive_d[i] = 1'b1;
          x_d[i]     = SX;
          y_d[i]     = spawn_y;
          lfsr_d     = lfsr_nx;
        end
      end
      if (kill_acc[i]) begin
        alive_d[i] = 1'b0;
        rc_d[i]    = RF;
      end
      score_d = score_d + SCORE_W'(kill_acc[i]);
    end
  end
  // diamond hit test; scanning high to low leaves the lowest covering index
  always_comb begin
    star_on_d = 1'b0;
    star_id_d = '0;
    rx = '0;
    ry = '0;
    dx = '0;
    dy = '0;
    for (int i = NUM_STARS - 1; i >= 0; i--) begin
      rx = pix_x - x_q[i];
      ry = pix_y - y_q[i];
      dx = rx >= R ? rx - R : R - rx;
      dy = ry >= R ? ry - R : R - ry;
      if (alive_q[i] && rx < SS && ry < SS && ({1'b0, dx} + {1'b0, dy}) <= {1'b0, R}) begin
        star_on_d = 1'b1;
        star_id_d = 3'(i);
      end
    end
  end
  // state registers with staggered initial respawn counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      alive_q   <= '0;
      lfsr_q    <= 16'hACE1;
      score_q   <= '0;
      star_on_q <= 1'b0;
      star_id_q <= '0;
      escaped_q <= 1'b0;
      for (int i = 0; i < NUM_STARS; i++) begin
        x_q[i]  <= SX;
        y_q[i]  <= '0;
        rc_q[i] <= 6'(1 + i * STAGGER_FRAMES);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      alive_q   <= alive_d;
      lfsr_q    <= lfsr_d;
      score_q   <= score_d;
      star_on_q <= star_on_d;
      star_id_q <= star_id_d;
      escaped_q <= escaped_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rc_q      <= rc_d;
    end
  end
  assign star_on = star_on_q;
  assign star_id = star_id_q;
  assign alive   = alive_q;
  assign score   = score_q;
  assign escaped = escaped_q;
  assign busy    = state_q == SWEEP;
endmodule

// File: doc/star_field.md
# star_field

Parametrised collectible-star generator for the game's pixel pipeline. It holds `NUM_STARS` independent stars that scroll right-to-left once per frame and respawn at pseudo-random heights after a programmable delay. It reports per-star alive state, a collect score and escape pulses, and produces a registered `star_on` / `star_id` for the colour mux.

## Interface
- `NUM_STARS`, default 4: number of stars (1–8).
- `STAR_SIZE`, default 16: bounding-box side in pixels; must be even. Diamond radius R = STAR_SIZE/2 − 1.
- `SPEED`, default 12: pixels moved left per frame.
- `SPAWN_X`, default 640: x coordinate assigned on spawn.
- `Y_RANGE`, default 400: spawn y is in [0, Y_RANGE). Legal range 256–512.
- `RESPAWN_FRAMES`, default 30: frames a star stays dead after being collected.
- `STAGGER_FRAMES`, default 8: reset-time spawn offset between consecutive stars.
- `SCORE_W`, default 8: score counter width.
- `clk`, in, 1: the single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per frame, start of vertical blank.
- `pix_x`, in, 10: current pixel x.
- `pix_y`, in, 10: current pixel y.
- `kill`, in, NUM_STARS: per-star collect request from the collision block, level-sampled every clock.
- `star_on`, out, 1: registered; current pixel lies on an alive star.
- `star_id`, out, 3: registered; lowest-index star covering the pixel. 0 when `star_on` is 0.
- `alive`, out, NUM_STARS: per-star alive flags.
- `score`, out, SCORE_W: count of collected stars. Wraps modulo 2^SCORE_W.
- `escaped`, out, 1: one-cycle pulse when any star leaves the left edge.
- `busy`, out, 1: a frame update sweep is in progress.

## Operation
- Per-star state: `alive` bit, x[9:0], y[9:0], respawn counter rc[5:0].
- Reset state:
  - All stars dead, x = SPAWN_X, y = 0, rc(i) = 1 + i·STAGGER_FRAMES.
  - LFSR = 16'hACE1.
  - `score` = 0; `star_on`, `star_id`, `escaped` and `busy` = 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances only when a spawn occurs.
- Spawn y: v = LFSR[8:0]. y = v if v < Y_RANGE, else v − Y_RANGE. The value is taken before the LFSR advances.
- Sweep FSM with states IDLE and SWEEP:
  - In IDLE, `frame_tick` moves to SWEEP with idx = 0 and `busy` = 1.
  - In SWEEP, star idx is updated each clock.
  - After idx = NUM_STARS−1 the FSM returns to IDLE.
  - `frame_tick` arriving during SWEEP is ignored.
- Update rules for star idx:
  - Alive, x < SPEED: becomes dead with rc = 1, and `escaped` pulses the next cycle. Score is unchanged.
  - Alive, otherwise: x = x − SPEED.
  - Dead, rc > 1: rc decrements.
  - Dead, rc ≤ 1: spawns with x = SPAWN_X, y = spawn y, alive = 1, and the LFSR advances.
- Kill handling:
  - Any clock, for every i with kill[i] = 1 and alive[i] = 1: alive[i] = 0 and rc[i] = RESPAWN_FRAMES.
  - Score increases by the popcount of the accepted kills that cycle.
  - Kill of a dead star is ignored.
  - If a kill and a sweep update target the same star in the same cycle, the kill wins: the star does not move and no escape is signalled.
- Pixel test for star i:
  - Offsets rx = pix_x − x, ry = pix_y − y, computed in 10 bits unsigned.
  - Pixel is in the box when rx < STAR_SIZE and ry < STAR_SIZE.
  - Pixel is on the star when |rx − R| + |ry − R| ≤ R, and the star must be alive.
  - Coordinates are not clipped; a wrapped rx fails the box test.

## Timing
- `star_on` / `star_id` latency is 1 clk from `pix_x` / `pix_y`, using the star state of that same cycle.
- A sweep takes NUM_STARS clocks. `busy` rises the clock after `frame_tick` and is high for exactly NUM_STARS cycles.
- Kill takes effect on the next edge: `alive` and `score` update one clock after kill is sampled.
- `escaped` goes high one clock after the escaping star's update cycle, for one cycle. It is an OR over stars.
- Reset asserted mid-sweep aborts the sweep and restores every reset value on the next edge.

## Test plan
- Reset, then 1 frame_tick with defaults: busy is high for 4 cycles; star0 spawns at x = 640, y = 225 (LFSR 0xACE1 → 0x0E1); alive = 4'b0001; stars 1–3 stay dead.
- Star0 alive at x = 640, frame_tick ×3: x = 628, 616, 604; star_on = 1 at pixel (611, 225+7) (diamond centre) one clock later; star_on = 0 at (604, 225), a box corner.
- kill = 4'b0001 for 1 clock while star0 is alive: alive[0] = 0 next clock, score = 1; 29 frames later star0 still dead; the 30th frame_tick respawns it.
- kill = 4'b0011 in one cycle with both stars alive: score += 2. Repeat kill[0] while dead: no change.
- Star at x = 8, frame_tick: escaped pulses exactly once, score unchanged, the star respawns on the next frame. Same setup with kill asserted on its update cycle: score + 1, no escaped pulse.
- frame_tick pulsed again while busy: sweep length unchanged and no star double-moved. Reset during SWEEP: all outputs return to reset values next clock.
